// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - request/response bundle between execute-stage control and the MDU
// master drives the operation request, slave returns the result handshake.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic [2:0]      FUNCT3;
  logic [XLEN-1:0] OP_A;
  logic [XLEN-1:0] OP_B;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;
  logic            DONE;

  modport master (
    output START, FUNCT3, OP_A, OP_B,
    input  RESULT, BUSY, DONE
  );

  modport slave (
    input  START, FUNCT3, OP_A, OP_B,
    output RESULT, BUSY, DONE
  );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit, one bit per clock
// Magnitudes are iterated unsigned; sign correction and output select happen in FIX.
module mdu_iterative #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic              CLK,
  input  logic              RST,
  mdu_iterative_if.slave    bus
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
  typedef enum logic [1:0] {SP_NONE, SP_DIVZ, SP_OVF} special_e;

  state_e            state_q;
  special_e          special_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   op_a_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic              neg_q;
  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   result_q;
  logic              busy_q;
  logic              done_q;

  // request decode, only meaningful in IDLE
  logic              signed_a_w;
  logic              signed_b_w;
  logic              sign_a_w;
  logic              sign_b_w;
  logic              neg_w;
  logic [XLEN-1:0]   abs_a_w;
  logic [XLEN-1:0]   abs_b_w;
  special_e          special_w;

  always_comb begin
    signed_a_w = 1'b0;
    signed_b_w = 1'b0;
    case (bus.FUNCT3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a_w = 1'b1;
        signed_b_w = 1'b1;
      end
      3'b010: signed_a_w = 1'b1;
      default: ;
    endcase
    sign_a_w = signed_a_w & bus.OP_A[XLEN-1];
    sign_b_w = signed_b_w & bus.OP_B[XLEN-1];
    abs_a_w  = sign_a_w ? (~bus.OP_A + 1'b1) : bus.OP_A;
    abs_b_w  = sign_b_w ? (~bus.OP_B + 1'b1) : bus.OP_B;
    // the remainder takes the dividend's sign; quotient and product take the xor
    if (bus.FUNCT3[2] && bus.FUNCT3[1]) begin
      neg_w = sign_a_w;
    end else begin
      neg_w = sign_a_w ^ sign_b_w;
    end
    special_w = SP_NONE;
    if (bus.FUNCT3[2] && (bus.OP_B == '0)) begin
      special_w = SP_DIVZ;
    end else if (bus.FUNCT3[2] && !bus.FUNCT3[0] &&
                 (bus.OP_A == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.OP_B == {XLEN{1'b1}})) begin
      special_w = SP_OVF;
    end
  end

  // one shift-add step: add multiplicand into the upper half, shift the product right
  logic [XLEN:0]     mul_sum_w;
  logic [2*XLEN-1:0] prod_next_w;

  assign mul_sum_w   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                       (prod_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
  assign prod_next_w = {mul_sum_w, prod_q[XLEN-1:1]};

  // one restoring step: the 33-bit partial remainder is compared against the divisor
  logic [XLEN:0]     div_shift_w;
  logic              div_ge_w;
  logic [XLEN-1:0]   div_sub_w;

  assign div_shift_w = {rem_q, quo_q[XLEN-1]};
  assign div_ge_w    = div_shift_w >= {1'b0, mag_b_q};
  assign div_sub_w   = div_shift_w[XLEN-1:0] - mag_b_q;

  // sign correction and output select
  logic [2*XLEN-1:0] prod_fix_w;
  logic [XLEN-1:0]   quo_fix_w;
  logic [XLEN-1:0]   rem_fix_w;
  logic [XLEN-1:0]   fix_result_w;

  always_comb begin
    prod_fix_w   = neg_q ? (~prod_q + 1'b1) : prod_q;
    quo_fix_w    = neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix_w    = neg_q ? (~rem_q + 1'b1) : rem_q;
    fix_result_w = '0;
    case (special_q)
      SP_DIVZ: fix_result_w = funct3_q[1] ? op_a_q : {XLEN{1'b1}};
      SP_OVF:  fix_result_w = funct3_q[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      default: begin
        if (funct3_q[2]) begin
          fix_result_w = funct3_q[1] ? rem_fix_w : quo_fix_w;
        end else if (funct3_q[1:0] == 2'b00) begin
          fix_result_w = prod_fix_w[XLEN-1:0];
        end else begin
          fix_result_w = prod_fix_w[2*XLEN-1:XLEN];
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      special_q <= SP_NONE;
      funct3_q  <= '0;
      op_a_q    <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            funct3_q  <= bus.FUNCT3;
            op_a_q    <= bus.OP_A;
            mag_a_q   <= abs_a_w;
            mag_b_q   <= abs_b_w;
            neg_q     <= neg_w;
            special_q <= special_w;
            count_q   <= '0;
            prod_q    <= {{XLEN{1'b0}}, abs_b_w};
            rem_q     <= '0;
            quo_q     <= abs_a_w;
            busy_q    <= 1'b1;
            state_q   <= (special_w == SP_NONE) ? S_CALC : S_FIX;
          end
        end
        S_CALC: begin
          count_q <= count_q + 1'b1;
          if (funct3_q[2]) begin
            rem_q <= div_ge_w ? div_sub_w : div_shift_w[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], div_ge_w};
          end else begin
            prod_q <= prod_next_w;
          end
          if (count_q == CW'(ITER - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_result_w;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.RESULT = result_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard bench for mdu_iterative with directed RV32M vectors
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iterative_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32), .ITER(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // monitor: every DONE pulse is matched against the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.DONE === 1'b1) begin
      check("busy_low_in_done", {31'b0, bus.BUSY}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=DONE required=no_done");
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, bus.RESULT, e.res);
        check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    exp_t e;
    bus.START  = 1'b1;
    bus.FUNCT3 = f;
    bus.OP_A   = a;
    bus.OP_B   = b;
    e.res = res;
    e.start_cyc = cyc;
    e.lat = lat;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (bus.DONE !== 1'b1 && n < 100) begin
      if (bus.BUSY === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.START  = 1'b1;
    bus.FUNCT3 = 3'b000;
    bus.OP_A   = 32'd5;
    bus.OP_B   = 32'd3;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, bus.BUSY}, 32'd0);
    check("reset_done", {31'b0, bus.DONE}, 32'd0);
    check("reset_result", bus.RESULT, 32'd0);
    rst       = 1'b0;
    bus.START = 1'b0;
    @(negedge clk);

    issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    wait_done(bc);
    check("mul_busy_cycles", 32'(bc), 32'd33);

    // back-to-back: each new START lands in the previous DONE cycle
    issue("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    wait_done(bc);
    issue("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    wait_done(bc);
    issue("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    wait_done(bc);
    issue("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    wait_done(bc);
    issue("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    wait_done(bc);
    issue("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    wait_done(bc);
    issue("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    wait_done(bc);
    issue("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    wait_done(bc);
    issue("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
    wait_done(bc);
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    wait_done(bc);
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    wait_done(bc);

    issue("divu_busy", 3'b101, 32'd1000, 32'd10, 32'd100, 34);
    repeat (3) @(negedge clk);
    bus.START  = 1'b1;
    bus.FUNCT3 = 3'b000;
    bus.OP_A   = 32'd77;
    bus.OP_B   = 32'd3;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(bc);
    repeat (40) @(negedge clk);

    issue("mul_abort", 3'b000, 32'd3, 32'd5, 32'd15, 34);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    check("abort_busy", {31'b0, bus.BUSY}, 32'd0);
    check("abort_done", {31'b0, bus.DONE}, 32'd0);
    check("abort_result", bus.RESULT, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue("remu_after", 3'b111, 32'd17, 32'd5, 32'd2, 34);
    wait_done(bc);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
